// File: rtl/easyaxi_ar_arb_if.sv
// rtl/easyaxi_ar_arb_if.sv - AR arbiter bundle: upstream requester AR lanes plus downstream AXI AR master
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

interface easyaxi_ar_arb_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    localparam int AW = `AXI_ADDR_WIDTH;

    logic [NUM_REQ-1:0]    req_arvalid;
    logic [NUM_REQ-1:0]    req_arready;
    logic [NUM_REQ*AW-1:0] req_araddr;
    logic                  axi_mst_arvalid;
    logic                  axi_mst_arready;
    logic [AW-1:0]         axi_mst_araddr;
    logic [ID_WIDTH-1:0]   axi_mst_arid;
    logic                  arb_busy;

    // slave: the arbiter's view; master: the surrounding requesters and downstream slave
    modport slave (
        input  req_arvalid, req_araddr, axi_mst_arready,
        output req_arready, axi_mst_arvalid, axi_mst_araddr, axi_mst_arid, arb_busy
    );
    modport master (
        output req_arvalid, req_araddr, axi_mst_arready,
        input  req_arready, axi_mst_arvalid, axi_mst_araddr, axi_mst_arid, arb_busy
    );
endinterface

// File: rtl/easyaxi_ar_arb.sv
// rtl/easyaxi_ar_arb.sv - round-robin arbiter sharing one AXI AR master among NUM_REQ requesters
// EASYAXI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and removes the rotating pointer.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module easyaxi_ar_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    easyaxi_ar_arb_if.slave   bus
);
    localparam int AW  = `AXI_ADDR_WIDTH;
    localparam int EXT = 2**ID_WIDTH;
    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ-1);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t         state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;

    logic [EXT-1:0]      valid_ext;
    logic [EXT-1:0]      ready_ext;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] winner;
    logic                winner_valid;
    logic [AW-1:0]       winner_addr;
    logic                slot_can_load;
    logic                upstream_hs;

`ifndef EASYAXI_ARB_FIXED_PRIO_EN
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Valid vector is widened to the full index space so the scan index selects without truncation.
    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = bus.req_arvalid;
        winner       = '0;
        winner_valid = 1'b0;
`ifdef EASYAXI_ARB_FIXED_PRIO_EN
        scan_idx = '0;
`else
        scan_idx = rr_ptr_q;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winner_valid && valid_ext[scan_idx]) begin
                winner_valid = 1'b1;
                winner       = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + ID_WIDTH'(1);
        end
    end

    always_comb begin
        winner_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_WIDTH'(i)) begin
                winner_addr = bus.req_araddr[i*AW +: AW];
            end
        end
    end

    // Ready is held low during reset so nothing is accepted into a slot that is being cleared.
    always_comb begin
        slot_can_load = !rst && ((state_q == SLOT_EMPTY) || bus.axi_mst_arready);
        upstream_hs   = slot_can_load && winner_valid;
        ready_ext     = '0;
        if (upstream_hs) begin
            ready_ext[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
`ifndef EASYAXI_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        if (upstream_hs) begin
            state_d = SLOT_FULL;
            addr_d  = winner_addr;
            id_d    = winner;
`ifndef EASYAXI_ARB_FIXED_PRIO_EN
            rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + ID_WIDTH'(1);
`endif
        end else if ((state_q == SLOT_FULL) && bus.axi_mst_arready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SLOT_EMPTY;
            addr_q   <= '0;
            id_q     <= '0;
`ifndef EASYAXI_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
`ifndef EASYAXI_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign bus.req_arready     = ready_ext[NUM_REQ-1:0];
    assign bus.axi_mst_arvalid = (state_q == SLOT_FULL);
    assign bus.axi_mst_araddr  = addr_q;
    assign bus.axi_mst_arid    = id_q;
    assign bus.arb_busy        = (state_q == SLOT_FULL);

endmodule
